vr_log_range_reader: RTL and testbench
======================================

# vr_log_range_reader

Parametrised two-pass reader for the replicated-operation log, used on the log-transfer path of the VR engine (state transfer and recovery replies). On a request for N consecutive entries from a circular header log, pass 1 walks the headers to sum the data-line count and capture the last header, then emits a size summary. Pass 2 streams each header beat, optionally followed by its data lines, into a valid/ready output toward the reply builder. Compared with the fixed-size in-controller, this block adds: a full internal datapath, a parametrised log depth with index wrap-around, a variable entry count including zero, and a header-only mode.

## Interface
- IDX_W, 8: header log index width; log depth is 2^IDX_W
- CNT_W, 8: request entry-count width
- LINES_W, 8: per-entry line-count field width
- DADDR_W, 12: data-memory address width
- HDR_W, 64: header word width; must satisfy HDR_W ≥ LINES_W+DADDR_W and ≤ DATA_W
- DATA_W, 512: data line width
- Header word layout: lines = hdr[LINES_W-1:0]; data start address = hdr[LINES_W +: DADDR_W]
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_val / req_rdy  in/out  1/1  request handshake
- req_start_idx  in  IDX_W  first header index
- req_num_entries  in  CNT_W  number of entries (0 legal)
- req_hdrs_only  in  1  1 = pass 2 emits headers only
- hdr_rd_req_val / hdr_rd_req_rdy  out/in  1/1  header memory read request
- hdr_rd_req_addr  out  IDX_W  header address
- hdr_rd_resp_val / hdr_rd_resp_rdy  in/out  1/1  header read response
- hdr_rd_resp_data  in  HDR_W  header word
- data_rd_req_val / data_rd_req_rdy  out/in  1/1  data memory read request
- data_rd_req_addr  out  DADDR_W  line address
- data_rd_resp_val / data_rd_resp_rdy  in/out  1/1  data read response
- data_rd_resp_data  in  DATA_W  line
- size_val / size_rdy  out/in  1/1  pass-1 summary handshake
- size_total_lines  out  LINES_W+CNT_W  sum of line counts
- size_last_hdr  out  HDR_W  last entry's header (0 if N=0)
- out_val / out_rdy  out/in  1/1  stream handshake
- out_data  out  DATA_W  header (zero-extended) or data line
- out_is_hdr  out  1  beat is a header
- out_last  out  1  final beat of the request
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, P1_REQ, P1_RESP, SIZE_OUT, P2_HREQ, P2_HRESP, HDR_OUT, D_REQ, D_RESP, D_OUT.
- IDLE: req_rdy=1. On req_val, latch the start, N and mode; clear entry counter i and total. If N=0, go to SIZE_OUT; otherwise go to P1_REQ.
- P1_REQ: hdr_rd_req_val with addr = start+i (mod 2^IDX_W). On rdy, go to P1_RESP.
- P1_RESP: hdr_rd_resp_rdy=1. On val: total += lines; if i=N-1, store the header as last_hdr, reset i to 0 and go to SIZE_OUT; else i++ and go to P1_REQ.
- SIZE_OUT: size_val=1. On size_rdy, go to IDLE if N=0, else go to P2_HREQ.
- P2_HREQ / P2_HRESP: same handshake as pass 1. On the response, latch the header, load daddr = start field and line counter j=0, and go to HDR_OUT.
- HDR_OUT: out_val=1, out_is_hdr=1, out_data = zero-extended header. out_last = (i=N-1) and (hdrs_only or lines=0). On out_rdy:
  - if hdrs_only or lines=0: go to IDLE if this is the last entry, else i++ and go to P2_HREQ;
  - otherwise go to D_REQ.
- D_REQ: data_rd_req_val with addr = daddr. On rdy, go to D_RESP.
- D_RESP: data_rd_resp_rdy=1. On val, latch the line and go to D_OUT.
- D_OUT: out_val=1, out_is_hdr=0, out_last = (i=N-1 and j=lines-1). On out_rdy, daddr++ (wraps mod 2^DADDR_W) and j++. Then:
  - if j=lines-1, go to IDLE if this is the last entry, else i++ and go to P2_HREQ;
  - otherwise go to D_REQ.
- At most one outstanding read per memory. resp_rdy is asserted only in the *_RESP states.
- Out-of-range log contents are not checked; lines=0 and the wrap from index 2^IDX_W-1 to 0 are both legal.

## Timing
- Reset values: state=IDLE; req_rdy=1. All other outputs are 0, including every val, every rdy, out_*, size_*, and busy.
- Outputs are decoded from registered state and payload registers. Payload stays stable while val is held and rdy is low.
- Read responses arrive no earlier than the cycle after the request is accepted.
- Zero-wait latency from request to size_val = 1 + 2N cycles. Each entry in pass 2 costs 3 cycles for the header plus 3 cycles per data line.
- A reset mid-request aborts immediately. The header and data memories share rst, so no stale responses are delivered.
- req_val is ignored while busy.

## Test plan
- Header-only, start=5, N=3, line counts 2/0/1 -> size_total_lines=3 and size_last_hdr = hdr[7]; then 3 header beats for indices 5, 6, 7, with out_last on the third only.
- Full mode, start=254, N=3 (indices 254, 255, 0), line counts 1/2/1 -> size_total=4; stream is H, D, H, D, D, H, D with data addresses taken from each header; out_last on the final D.
- N=0 -> one size beat (total 0, hdr 0), no out beats, return to IDLE; the next request is accepted.
- Random backpressure on out_rdy, size_rdy, and both memories' req_rdy and resp latency -> stream identical to the zero-wait run; payload stable while stalled.
- rst asserted in D_OUT of a 4-entry request -> next cycle: IDLE, all outputs at their reset values; a fresh request completes correctly.
- Entry whose data start is 4095 with lines=2 -> data reads at addresses 4095 then 0.

Source files
------------

// File: rtl/vr_log_range_reader.sv
// ---------------------------------------------------------------------------
// vr_log_range_reader
//   Two-pass reader for a circular replicated-operation header log.
//   Pass 1 walks N headers, sums their data-line counts, captures the last
//   header and offers a size summary. Pass 2 streams each header beat,
//   optionally followed by its data lines, on a valid/ready output.
//
// Ports
//   clk, rst                          clock, synchronous active-high reset
//   req_*                             request: start index, entry count, mode
//   hdr_rd_req_* / hdr_rd_resp_*      header memory read port
//   data_rd_req_* / data_rd_resp_*    data memory read port
//   size_*                            pass-1 summary (total lines, last header)
//   out_*                             pass-2 stream (header or data beats)
//   busy                              high whenever the FSM is not idle
// ---------------------------------------------------------------------------
module vr_log_range_reader #(
  parameter int IDX_W   = 8,
  parameter int CNT_W   = 8,
  parameter int LINES_W = 8,
  parameter int DADDR_W = 12,
  parameter int HDR_W   = 64,
  parameter int DATA_W  = 512
) (
  input  logic                       clk,
  input  logic                       rst,

  input  logic                       req_val,
  output logic                       req_rdy,
  input  logic [IDX_W-1:0]           req_start_idx,
  input  logic [CNT_W-1:0]           req_num_entries,
  input  logic                       req_hdrs_only,

  output logic                       hdr_rd_req_val,
  input  logic                       hdr_rd_req_rdy,
  output logic [IDX_W-1:0]           hdr_rd_req_addr,
  input  logic                       hdr_rd_resp_val,
  output logic                       hdr_rd_resp_rdy,
  input  logic [HDR_W-1:0]           hdr_rd_resp_data,

  output logic                       data_rd_req_val,
  input  logic                       data_rd_req_rdy,
  output logic [DADDR_W-1:0]         data_rd_req_addr,
  input  logic                       data_rd_resp_val,
  output logic                       data_rd_resp_rdy,
  input  logic [DATA_W-1:0]          data_rd_resp_data,

  output logic                       size_val,
  input  logic                       size_rdy,
  output logic [LINES_W+CNT_W-1:0]   size_total_lines,
  output logic [HDR_W-1:0]           size_last_hdr,

  output logic                       out_val,
  input  logic                       out_rdy,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_is_hdr,
  output logic                       out_last,

  output logic                       busy
);

  localparam int TOT_W = LINES_W + CNT_W;

  typedef enum logic [3:0] {
    IDLE, P1_REQ, P1_RESP, SIZE_OUT, P2_HREQ, P2_HRESP,
    HDR_OUT, D_REQ, D_RESP, D_OUT
  } state_t;

  state_t              state;
  logic [IDX_W-1:0]    start;
  logic [CNT_W-1:0]    num;
  logic                hdrs_only;
  logic [CNT_W-1:0]    i;         // entry index within the request
  logic [LINES_W-1:0]  j;         // data line index within the entry
  logic [TOT_W-1:0]    total;
  logic [HDR_W-1:0]    last_hdr;
  logic [HDR_W-1:0]    hdr;       // pass-2 header of the current entry
  logic [DADDR_W-1:0]  daddr;
  logic [DATA_W-1:0]   line;

  logic [LINES_W-1:0]  cur_lines;
  logic [LINES_W-1:0]  resp_lines;
  logic                last_entry;
  logic                no_data;
  logic                last_line;

  assign cur_lines  = hdr[LINES_W-1:0];
  assign resp_lines = hdr_rd_resp_data[LINES_W-1:0];
  assign last_entry = (i == num - CNT_W'(1));
  assign no_data    = hdrs_only || (cur_lines == '0);
  assign last_line  = (j == cur_lines - LINES_W'(1));

  // Every output is a decode of registered state and payload registers,
  // so nothing here depends combinationally on an input.
  assign req_rdy          = (state == IDLE);
  assign busy             = (state != IDLE);
  assign hdr_rd_req_val   = (state == P1_REQ) || (state == P2_HREQ);
  assign hdr_rd_req_addr  = start + IDX_W'(i);   // wraps mod 2^IDX_W
  assign hdr_rd_resp_rdy  = (state == P1_RESP) || (state == P2_HRESP);
  assign data_rd_req_val  = (state == D_REQ);
  assign data_rd_req_addr = daddr;
  assign data_rd_resp_rdy = (state == D_RESP);
  assign size_val         = (state == SIZE_OUT);
  assign size_total_lines = size_val ? total : '0;
  assign size_last_hdr    = size_val ? last_hdr : '0;
  assign out_val          = (state == HDR_OUT) || (state == D_OUT);
  assign out_is_hdr       = (state == HDR_OUT);
  assign out_data         = (state == HDR_OUT) ? DATA_W'(hdr) :
                            (state == D_OUT)   ? line : '0;
  assign out_last         = ((state == HDR_OUT) && last_entry && no_data) ||
                            ((state == D_OUT) && last_entry && last_line);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      start     <= '0;
      num       <= '0;
      hdrs_only <= 1'b0;
      i         <= '0;
      j         <= '0;
      total     <= '0;
      last_hdr  <= '0;
      hdr       <= '0;
      daddr     <= '0;
      line      <= '0;
    end else begin
      unique case (state)
        IDLE: if (req_val) begin
          start     <= req_start_idx;
          num       <= req_num_entries;
          hdrs_only <= req_hdrs_only;
          i         <= '0;
          total     <= '0;
          last_hdr  <= '0;
          state     <= (req_num_entries == '0) ? SIZE_OUT : P1_REQ;
        end
        P1_REQ: if (hdr_rd_req_rdy) state <= P1_RESP;
        P1_RESP: if (hdr_rd_resp_val) begin
          total <= total + TOT_W'(resp_lines);
          if (last_entry) begin
            last_hdr <= hdr_rd_resp_data;
            i        <= '0;
            state    <= SIZE_OUT;
          end else begin
            i     <= i + CNT_W'(1);
            state <= P1_REQ;
          end
        end
        SIZE_OUT: if (size_rdy) state <= (num == '0) ? IDLE : P2_HREQ;
        P2_HREQ: if (hdr_rd_req_rdy) state <= P2_HRESP;
        P2_HRESP: if (hdr_rd_resp_val) begin
          hdr   <= hdr_rd_resp_data;
          daddr <= hdr_rd_resp_data[LINES_W +: DADDR_W];
          j     <= '0;
          state <= HDR_OUT;
        end
        HDR_OUT: if (out_rdy) begin
          if (!no_data) begin
            state <= D_REQ;
          end else if (last_entry) begin
            state <= IDLE;
          end else begin
            i     <= i + CNT_W'(1);
            state <= P2_HREQ;
          end
        end
        D_REQ: if (data_rd_req_rdy) state <= D_RESP;
        D_RESP: if (data_rd_resp_val) begin
          line  <= data_rd_resp_data;
          state <= D_OUT;
        end
        D_OUT: if (out_rdy) begin
          daddr <= daddr + DADDR_W'(1);   // wraps mod 2^DADDR_W
          j     <= j + LINES_W'(1);
          if (!last_line) begin
            state <= D_REQ;
          end else if (last_entry) begin
            state <= IDLE;
          end else begin
            i     <= i + CNT_W'(1);
            state <= P2_HREQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vr_log_range_reader.sv
// ---------------------------------------------------------------------------
// tb_vr_log_range_reader
//   Self-checking bench for vr_log_range_reader. Header and data memories are
//   behavioural responders; expected size summaries and output streams come
//   from a loop-level model of the log walk. All driving and sampling happens
//   on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_vr_log_range_reader;

  localparam int IDX_W = 8, CNT_W = 8, LINES_W = 8, DADDR_W = 12;
  localparam int HDR_W = 64, DATA_W = 512;

  logic               clk = 1'b0;
  logic               rst;
  logic               req_val, req_rdy, req_hdrs_only;
  logic [IDX_W-1:0]   req_start_idx;
  logic [CNT_W-1:0]   req_num_entries;
  logic               hdr_rd_req_val, hdr_rd_req_rdy;
  logic [IDX_W-1:0]   hdr_rd_req_addr;
  logic               hdr_rd_resp_val, hdr_rd_resp_rdy;
  logic [HDR_W-1:0]   hdr_rd_resp_data;
  logic               data_rd_req_val, data_rd_req_rdy;
  logic [DADDR_W-1:0] data_rd_req_addr;
  logic               data_rd_resp_val, data_rd_resp_rdy;
  logic [DATA_W-1:0]  data_rd_resp_data;
  logic               size_val, size_rdy;
  logic [15:0]        size_total_lines;
  logic [HDR_W-1:0]   size_last_hdr;
  logic               out_val, out_rdy, out_is_hdr, out_last, busy;
  logic [DATA_W-1:0]  out_data;

  vr_log_range_reader dut (
    .clk(clk), .rst(rst),
    .req_val(req_val), .req_rdy(req_rdy), .req_start_idx(req_start_idx),
    .req_num_entries(req_num_entries), .req_hdrs_only(req_hdrs_only),
    .hdr_rd_req_val(hdr_rd_req_val), .hdr_rd_req_rdy(hdr_rd_req_rdy),
    .hdr_rd_req_addr(hdr_rd_req_addr), .hdr_rd_resp_val(hdr_rd_resp_val),
    .hdr_rd_resp_rdy(hdr_rd_resp_rdy), .hdr_rd_resp_data(hdr_rd_resp_data),
    .data_rd_req_val(data_rd_req_val), .data_rd_req_rdy(data_rd_req_rdy),
    .data_rd_req_addr(data_rd_req_addr), .data_rd_resp_val(data_rd_resp_val),
    .data_rd_resp_rdy(data_rd_resp_rdy), .data_rd_resp_data(data_rd_resp_data),
    .size_val(size_val), .size_rdy(size_rdy), .size_total_lines(size_total_lines),
    .size_last_hdr(size_last_hdr), .out_val(out_val), .out_rdy(out_rdy),
    .out_data(out_data), .out_is_hdr(out_is_hdr), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              is_hdr;
    logic              last;
  } beat_t;

  typedef struct packed {
    logic [15:0]      total;
    logic [HDR_W-1:0] hdr;
  } size_t;

  typedef struct {
    int start;
    int n;
    bit mode;
    int exp_total;
    int exp_beats;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [HDR_W-1:0]   hmem [256];
  beat_t              got_beats[$], exp_beats[$];
  size_t              got_sizes[$];
  logic [DADDR_W-1:0] got_daddr[$], exp_daddr[$];
  size_t              exp_size;

  bit                 bp;            // random backpressure and latency
  bit                 h_busy, d_busy;
  int                 h_delay, d_delay;
  logic [IDX_W-1:0]   h_addr;
  logic [DADDR_W-1:0] d_addr;
  bit                 out_stall, size_stall;
  logic [513:0]       out_prev;
  logic [79:0]        size_prev;

  task automatic check(string name, logic [575:0] act, logic [575:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [HDR_W-1:0] mk_hdr(int idx, int lines, int daddr);
    logic [31:0] tag;
    tag = 32'(idx) * 32'h9E3779B1;
    return {12'h0, tag, 12'(daddr), 8'(lines)};
  endfunction

  function automatic logic [DATA_W-1:0] dword(logic [DADDR_W-1:0] a);
    logic [31:0] w;
    w = {20'hD0000 ^ {8'h0, a}, a};
    return {16{w}};
  endfunction

  // Reference model: walk the log entry by entry using plain arithmetic.
  task automatic build_expected(int start, int n, bit mode);
    int tot;
    exp_beats.delete();
    exp_daddr.delete();
    tot = 0;
    for (int e = 0; e < n; e++) begin
      logic [HDR_W-1:0] h;
      int lines, base;
      beat_t b;
      h     = hmem[(start + e) % 256];
      lines = int'(h[7:0]);
      base  = int'(h[19:8]);
      tot  += lines;
      b.data = DATA_W'(h); b.is_hdr = 1'b1;
      b.last = (e == n - 1) && (mode || lines == 0);
      exp_beats.push_back(b);
      if (!mode) begin
        for (int k = 0; k < lines; k++) begin
          logic [DADDR_W-1:0] a;
          a = DADDR_W'((base + k) % 4096);
          b.data = dword(a); b.is_hdr = 1'b0;
          b.last = (e == n - 1) && (k == lines - 1);
          exp_beats.push_back(b);
          exp_daddr.push_back(a);
        end
      end
    end
    exp_size.total = 16'(tot);
    exp_size.hdr   = (n == 0) ? '0 : hmem[(start + n - 1) % 256];
  endtask

  // One clock of bench activity: stability checks, memory responders,
  // sink handshakes. Inputs set here apply to the following rising edge.
  task automatic step();
    @(negedge clk);
    if (out_stall)
      check("out_stable", {61'b0, out_val, out_is_hdr, out_last, out_data},
            {61'b0, 1'b1, out_prev});
    if (size_stall)
      check("size_stable", {495'b0, size_val, size_total_lines, size_last_hdr},
            {495'b0, 1'b1, size_prev});

    req_val = 1'b0;
    if (bp && busy) begin
      req_val         = 1'($urandom_range(0, 1));
      req_start_idx   = 8'($urandom);
      req_num_entries = 8'($urandom);
      req_hdrs_only   = 1'($urandom_range(0, 1));
    end

    hdr_rd_resp_val = 1'b0;
    if (h_busy) begin
      if (h_delay > 0) h_delay--;
      else begin
        hdr_rd_resp_val  = 1'b1;
        hdr_rd_resp_data = hmem[h_addr];
        if (hdr_rd_resp_rdy) h_busy = 1'b0;
      end
    end
    hdr_rd_req_rdy = h_busy ? 1'b0 : (bp ? 1'($urandom_range(0, 1)) : 1'b1);
    if (hdr_rd_req_val && hdr_rd_req_rdy) begin
      h_busy  = 1'b1;
      h_addr  = hdr_rd_req_addr;
      h_delay = bp ? int'($urandom_range(0, 3)) : 0;
    end

    data_rd_resp_val = 1'b0;
    if (d_busy) begin
      if (d_delay > 0) d_delay--;
      else begin
        data_rd_resp_val  = 1'b1;
        data_rd_resp_data = dword(d_addr);
        if (data_rd_resp_rdy) d_busy = 1'b0;
      end
    end
    data_rd_req_rdy = d_busy ? 1'b0 : (bp ? 1'($urandom_range(0, 1)) : 1'b1);
    if (data_rd_req_val && data_rd_req_rdy) begin
      d_busy  = 1'b1;
      d_addr  = data_rd_req_addr;
      d_delay = bp ? int'($urandom_range(0, 3)) : 0;
      got_daddr.push_back(data_rd_req_addr);
    end

    size_rdy = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (size_val && size_rdy) got_sizes.push_back({size_total_lines, size_last_hdr});
    size_stall = size_val && !size_rdy;
    size_prev  = {size_total_lines, size_last_hdr};

    out_rdy = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (out_val && out_rdy) got_beats.push_back({out_data, out_is_hdr, out_last});
    out_stall = out_val && !out_rdy;
    out_prev  = {out_is_hdr, out_last, out_data};
  endtask

  // Issue one request and compare everything the DUT produced to the model.
  task automatic run_req(int start, int n, bit mode, bit chk_lat);
    int  lat;
    bit  done;
    int  cnt;
    build_expected(start, n, mode);
    got_beats.delete(); got_sizes.delete(); got_daddr.delete();
    check("req_rdy_idle", 576'(req_rdy), 576'(1));
    req_val = 1'b1; req_start_idx = 8'(start);
    req_num_entries = 8'(n); req_hdrs_only = mode;
    lat = -1; done = 1'b0;
    for (int c = 1; c <= 4000 && !done; c++) begin
      step();
      if (lat < 0 && size_val) lat = c;
      done = (got_sizes.size() >= 1) && (got_beats.size() >= exp_beats.size()) && !busy;
    end
    check("req_complete", 576'(done), 576'(1));
    if (chk_lat) check("size_latency", 576'(lat), 576'(1 + 2 * n));
    check("size_count", 576'(got_sizes.size()), 576'(1));
    if (got_sizes.size() > 0) begin
      check("size_total", 576'(got_sizes[0].total), 576'(exp_size.total));
      check("size_last_hdr", 576'(got_sizes[0].hdr), 576'(exp_size.hdr));
    end
    check("beat_count", 576'(got_beats.size()), 576'(exp_beats.size()));
    cnt = (got_beats.size() < exp_beats.size()) ? got_beats.size() : exp_beats.size();
    for (int b = 0; b < cnt; b++)
      check($sformatf("beat[%0d]", b), {62'b0, got_beats[b].is_hdr, got_beats[b].last,
            got_beats[b].data}, {62'b0, exp_beats[b].is_hdr, exp_beats[b].last,
            exp_beats[b].data});
    check("daddr_count", 576'(got_daddr.size()), 576'(exp_daddr.size()));
    cnt = (got_daddr.size() < exp_daddr.size()) ? got_daddr.size() : exp_daddr.size();
    for (int b = 0; b < cnt; b++)
      check($sformatf("daddr[%0d]", b), 576'(got_daddr[b]), 576'(exp_daddr[b]));
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_ctrl"}, 576'({req_rdy, busy, hdr_rd_req_val, hdr_rd_resp_rdy,
          data_rd_req_val, data_rd_resp_rdy, size_val, out_val, out_is_hdr,
          out_last}), 576'(10'b10_0000_0000));
    check({tag, "_out_data"}, 576'(out_data), 576'(0));
    check({tag, "_size"}, 576'({size_total_lines, size_last_hdr}), 576'(0));
    check({tag, "_addr"}, 576'({hdr_rd_req_addr, data_rd_req_addr}), 576'(0));
  endtask

  task automatic clear_bench_inputs();
    req_val = 1'b0; req_start_idx = '0; req_num_entries = '0; req_hdrs_only = 1'b0;
    hdr_rd_req_rdy = 1'b0; hdr_rd_resp_val = 1'b0; hdr_rd_resp_data = '0;
    data_rd_req_rdy = 1'b0; data_rd_resp_val = 1'b0; data_rd_resp_data = '0;
    size_rdy = 1'b0; out_rdy = 1'b0;
    h_busy = 1'b0; d_busy = 1'b0; h_delay = 0; d_delay = 0;
    out_stall = 1'b0; size_stall = 1'b0;
  endtask

  vec_t vecs[5];

  initial begin
    bit found;
    vecs[0] = '{start: 5,   n: 3, mode: 1'b1, exp_total: 3, exp_beats: 3};
    vecs[1] = '{start: 254, n: 3, mode: 1'b0, exp_total: 4, exp_beats: 7};
    vecs[2] = '{start: 0,   n: 0, mode: 1'b0, exp_total: 0, exp_beats: 0};
    vecs[3] = '{start: 20,  n: 1, mode: 1'b0, exp_total: 2, exp_beats: 3};
    vecs[4] = '{start: 5,   n: 3, mode: 1'b0, exp_total: 3, exp_beats: 6};

    for (int k = 0; k < 256; k++)
      hmem[k] = mk_hdr(k, int'($urandom_range(0, 3)), int'($urandom_range(0, 4095)));
    hmem[5]   = mk_hdr(5, 2, 10);
    hmem[6]   = mk_hdr(6, 0, 20);
    hmem[7]   = mk_hdr(7, 1, 30);
    hmem[254] = mk_hdr(254, 1, 500);
    hmem[255] = mk_hdr(255, 2, 600);
    hmem[0]   = mk_hdr(0, 1, 700);
    hmem[20]  = mk_hdr(20, 2, 4095);
    hmem[40]  = mk_hdr(40, 1, 100);
    hmem[41]  = mk_hdr(41, 2, 200);
    hmem[42]  = mk_hdr(42, 1, 300);
    hmem[43]  = mk_hdr(43, 3, 400);

    bp = 1'b0;
    clear_bench_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("reset");

    // Table vectors: zero-wait (with latency check), then under backpressure.
    foreach (vecs[v]) begin
      for (int pass = 0; pass < 2; pass++) begin
        bp = (pass == 1);
        run_req(vecs[v].start, vecs[v].n, vecs[v].mode, !bp);
        if (got_sizes.size() > 0)
          check($sformatf("tbl%0d_total", v), 576'(got_sizes[0].total),
                576'(vecs[v].exp_total));
        check($sformatf("tbl%0d_beats", v), 576'(got_beats.size()),
              576'(vecs[v].exp_beats));
      end
    end

    // Header-only run: summary carries index 7's header; last flag on beat 3 only.
    bp = 1'b0;
    run_req(5, 3, 1'b1, 1'b0);
    if (got_sizes.size() > 0)
      check("hdr_only_last_hdr", 576'(got_sizes[0].hdr), 576'(mk_hdr(7, 1, 30)));
    if (got_beats.size() == 3)
      check("hdr_only_last_flags", 576'({got_beats[0].last, got_beats[1].last,
            got_beats[2].last}), 576'(3'b001));

    // Data address wrap 4095 -> 0.
    run_req(20, 1, 1'b0, 1'b0);
    if (got_daddr.size() == 2)
      check("daddr_wrap", 576'({got_daddr[0], got_daddr[1]}), 576'({12'd4095, 12'd0}));
    else
      check("daddr_wrap_count", 576'(got_daddr.size()), 576'(2));

    // Reset while a 4-entry request sits in a data-output beat.
    got_beats.delete(); got_sizes.delete(); got_daddr.delete();
    req_val = 1'b1; req_start_idx = 8'd40; req_num_entries = 8'd4; req_hdrs_only = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      step();
      found = out_val && !out_is_hdr;
    end
    check("reach_d_out", 576'(found), 576'(1));
    clear_bench_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("mid_rst");
    run_req(40, 4, 1'b0, 1'b1);

    // Randomized requests under backpressure and memory latency.
    bp = 1'b1;
    for (int r = 0; r < 25; r++)
      run_req(int'($urandom_range(0, 255)), int'($urandom_range(0, 6)),
              1'($urandom_range(0, 1)), 1'b0);

    bp = 1'b0;
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
